// File: rtl/prog_loader.sv
// Boot loader: byte stream -> little-endian 32-bit words -> instruction memory; holds the core in reset until the image is complete.
// Optional checksum byte after the payload, enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t              state_q;
  logic [7:0]          n_lo_q;
  logic [15:0]         n_q;
  logic [15:0]         k_q;
  logic [1:0]          idx_q;
  logic [23:0]         word_q;
  logic                im_we_q;
  logic [ADDR_W-1:0]   im_addr_q;
  logic [31:0]         im_wdata_q;
  logic                cpu_reset_q;
  logic                done_q;
  logic                error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic        accept;
  logic [15:0] n_hdr;

  always_comb begin
    in_ready = (state_q != S_DONE) && (state_q != S_ERR);
    accept   = in_valid && in_ready;
    n_hdr    = {in_data, n_lo_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HDR0;
      n_lo_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      im_we_q     <= 1'b0;
      done_q      <= (state_q == S_DONE);
      error_q     <= (state_q == S_ERR);
      // Release follows DONE by one cycle; a reload re-asserts it on the same edge.
      cpu_reset_q <= !((state_q == S_DONE) && !reload);
      case (state_q)
        S_HDR0: if (accept) begin
          n_lo_q  <= in_data;
          state_q <= S_HDR1;
        end
        S_HDR1: if (accept) begin
          n_q <= n_hdr;
          if (n_hdr > 16'(DEPTH))  state_q <= S_ERR;
          else if (n_hdr == 16'd0) state_q <= S_FINAL;
          else                     state_q <= S_DATA;
        end
        S_DATA: if (accept) begin
          idx_q <= idx_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ in_data;
`endif
          case (idx_q)
            2'd0: word_q[7:0]   <= in_data;
            2'd1: word_q[15:8]  <= in_data;
            2'd2: word_q[23:16] <= in_data;
            default: begin
              im_we_q    <= 1'b1;
              im_addr_q  <= k_q[ADDR_W-1:0];
              im_wdata_q <= {in_data, word_q};
              k_q        <= k_q + 16'd1;
              if (k_q + 16'd1 == n_q) state_q <= S_FINAL;
            end
          endcase
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: if (accept) state_q <= (in_data == csum_q) ? S_DONE : S_ERR;
`endif
        default: if (reload) begin
          state_q <= S_HDR0;
          n_lo_q  <= '0;
          n_q     <= '0;
          k_q     <= '0;
          idx_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end
      endcase
    end
  end

  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header/payload streaming, length bounds, reload, mid-load reset, optional checksum.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  txor;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  prog_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (im_we) begin
    log_a.push_back(32'(im_addr));
    log_d.push_back(im_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic hdr(input logic [15:0] n);
    txor = 8'h00;
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      txor ^= w[8*i +: 8];
      if (gaps && i < 3) repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic end_image();
`ifdef PROG_LOADER_CHECKSUM_EN
    send(txor);
`endif
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".we"},    32'(im_we), 32'd0);
    chk({tag, ".addr"},  32'(im_addr), 32'd0);
    chk({tag, ".wdata"}, im_wdata, 32'd0);
    chk({tag, ".cpurst"},32'(cpu_reset), 32'd1);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".err"},   32'(error), 32'd0);
    chk({tag, ".rdy"},   32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset values
    #12;
    chk_reset_vals("rst");
    reset = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // Basic two-word image
    hdr(16'd2);
    send_word(32'h00000013, 1'b0);
    chk("w0.we", 32'(im_we), 32'd1);
    chk("w0.addr", 32'(im_addr), 32'd0);
    chk("w0.data", im_wdata, 32'h00000013);
    send_word(32'h12345678, 1'b0);
    chk("w1.we", 32'(im_we), 32'd1);
    chk("w1.addr", 32'(im_addr), 32'd1);
    chk("w1.data", im_wdata, 32'h12345678);
    end_image();
    chk("rel.hold", 32'(cpu_reset), 32'd1);
    chk("rel.done0", 32'(done), 32'd0);
    step();
    chk("rel.cpurst", 32'(cpu_reset), 32'd0);
    chk("rel.done", 32'(done), 32'd1);
    chk("rel.we", 32'(im_we), 32'd0);
    chk("rel.rdy", 32'(in_ready), 32'd0);
    chk("log.n", 32'(log_a.size()), 32'd2);

    // Reload from DONE
    pulse_reload();
    chk("rl.cpurst", 32'(cpu_reset), 32'd1);
    chk("rl.rdy", 32'(in_ready), 32'd1);
    chk("rl.done_hold", 32'(done), 32'd1);
    step();
    chk("rl.done_clr", 32'(done), 32'd0);

    // Oversize header -> ERR
    log_a.delete(); log_d.delete();
    hdr(16'd257);
    chk("err.rdy", 32'(in_ready), 32'd0);
    chk("err.e0", 32'(error), 32'd0);
    step();
    chk("err.e1", 32'(error), 32'd1);
    chk("err.cpurst", 32'(cpu_reset), 32'd1);
    in_data = 8'hFF; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    chk("err.nowr", 32'(log_a.size()), 32'd0);
    chk("err.stay", 32'(error), 32'd1);

    // N = DEPTH accepted, fills every address
    pulse_reload();
    step();
    chk("max.eclr", 32'(error), 32'd0);
    hdr(16'd256);
    step();
    chk("max.rdy", 32'(in_ready), 32'd1);
    chk("max.e", 32'(error), 32'd0);
    for (int i = 0; i < 256; i++) send_word({i[7:0], 8'hA5, ~i[7:0], 8'h3C}, 1'b0);
    end_image();
    step();
    chk("max.done", 32'(done), 32'd1);
    chk("max.n", 32'(log_a.size()), 32'd256);
    chk("max.a0", log_a[0], 32'd0);
    chk("max.a255", log_a[255], 32'd255);
    chk("max.d255", log_d[255], 32'hFFA5003C);
    chk("max.d7", log_d[7], 32'h07A5F83C);

    // In-word valid gaps
    pulse_reload();
    log_a.delete(); log_d.delete();
    hdr(16'd2);
    send(8'h13); step(); step(); send(8'h00); step(); send(8'h00); step(); step(); step();
    chk("gap.nowe", 32'(im_we), 32'd0);
    chk("gap.n0", 32'(log_a.size()), 32'd0);
    send(8'h00);
    txor = 8'h13;
    chk("gap.we", 32'(im_we), 32'd1);
    send_word(32'h12345678, 1'b1);
    end_image();
    step();
    chk("gap.done", 32'(done), 32'd1);
    chk("gap.n", 32'(log_a.size()), 32'd2);
    chk("gap.a0", log_a[0], 32'd0);
    chk("gap.d0", log_d[0], 32'h00000013);
    chk("gap.a1", log_a[1], 32'd1);
    chk("gap.d1", log_d[1], 32'h12345678);

    // reload during DATA has no effect
    pulse_reload();
    log_a.delete(); log_d.delete();
    hdr(16'd2);
    send_word(32'hDEADBEEF, 1'b0);
    send(8'h78); send(8'h56);
    pulse_reload();
    chk("rld.rdy", 32'(in_ready), 32'd1);
    chk("rld.cpurst", 32'(cpu_reset), 32'd1);
    chk("rld.done", 32'(done), 32'd0);
    send(8'h34); send(8'h12);
    txor = txor ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12;
    end_image();
    step();
    chk("rld.fin", 32'(done), 32'd1);
    chk("rld.n", 32'(log_a.size()), 32'd2);
    chk("rld.a1", log_a[1], 32'd1);
    chk("rld.d1", log_d[1], 32'h12345678);

    // Reset mid-load, then a fresh image from address 0
    pulse_reload();
    log_a.delete(); log_d.delete();
    hdr(16'd2);
    send_word(32'h11111111, 1'b0);
    send(8'h22); send(8'h22);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    step();
    reset = 1'b1;
    step();
    chk("mid.n", 32'(log_a.size()), 32'd1);
    hdr(16'd1);
    send_word(32'hCAFEF00D, 1'b0);
    end_image();
    step();
    chk("mid.done", 32'(done), 32'd1);
    chk("mid.a", log_a[1], 32'd0);
    chk("mid.d", log_d[1], 32'hCAFEF00D);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_reload();
    log_a.delete(); log_d.delete();
    hdr(16'd1);
    send_word(32'hAABBCCDD, 1'b0);
    send(8'h00);
    step();
    chk("cs.ok", 32'(done), 32'd1);
    pulse_reload();
    hdr(16'd1);
    send_word(32'hAABBCCDD, 1'b0);
    send(8'h01);
    step();
    chk("cs.err", 32'(error), 32'd1);
    chk("cs.nd", 32'(done), 32'd0);
    chk("cs.n", 32'(log_a.size()), 32'd2);
    chk("cs.a", log_a[1], 32'd0);
    chk("cs.d", log_d[1], 32'hAABBCCDD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
